// File: rtl/tcm_port_arb.sv
// tcm_port_arb: arbitrates one port of the 64-bit x 16K-entry TCM between
// requester A (core LSU, fixed priority) and requester B (DMA / debug loader).
// Each cycle issues at most one grant. A starvation counter forces a B grant
// after STARVE_LIMIT refusals. A bounded lock lets B keep the port for bursts
// of up to LOCK_MAX grants. Responses come back through a 1-cycle ack pipe
// that matches the RAM's registered read.

module tcm_port_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req_a_rd_i,
    input  logic [7:0]  req_a_wr_i,
    input  logic [13:0] req_a_addr_i,
    input  logic [63:0] req_a_data_i,
    output logic        req_a_accept_o,
    output logic        req_a_ack_o,
    output logic [63:0] req_a_data_o,

    input  logic        req_b_rd_i,
    input  logic [7:0]  req_b_wr_i,
    input  logic [13:0] req_b_addr_i,
    input  logic [63:0] req_b_data_i,
    input  logic        req_b_lock_i,
    output logic        req_b_accept_o,
    output logic        req_b_ack_o,
    output logic [63:0] req_b_data_o,

    output logic [13:0] ram_addr_o,
    output logic [63:0] ram_data_o,
    output logic [7:0]  ram_wr_o,
    input  logic [63:0] ram_data_i
);

    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] LP_LOCK_MAX     = 4'(LOCK_MAX);
    // With LOCK_MAX == 1, the entering grant is already the whole burst,
    // so the arbiter never enters LOCK_B.
    localparam logic       LP_LOCK_EN      = (LOCK_MAX > 1);

    typedef enum logic [1:0] {
        PRI_A  = 2'd0,
        PRI_B  = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_nxt;
    logic [3:0]  r_lock_cnt;
    logic [3:0]  w_lock_nxt;
    logic [3:0]  w_lock_inc;

    logic        w_pend_a;
    logic        w_pend_b;
    logic        w_gnt_a;
    logic        w_gnt_b;

    logic        r_ack_vld_p1;
    logic        r_ack_sel_p1;

    // A side or B side has work when it asks to read or enables any write byte.
    always_comb begin
        w_pend_a = req_a_rd_i | (|req_a_wr_i);
        w_pend_b = req_b_rd_i | (|req_b_wr_i);
    end

    // Arbitration FSM: select the winner, then compute the next state and the next counter values.
    always_comb begin
        w_state_nxt  = r_state;
        w_lock_nxt   = r_lock_cnt;
        w_lock_inc   = r_lock_cnt + 4'd1;
        w_gnt_a      = 1'b0;
        w_gnt_b      = 1'b0;

        case (r_state)
            PRI_A: begin
                if (w_pend_a) begin
                    w_gnt_a = 1'b1;
                end else if (w_pend_b) begin
                    w_gnt_b = 1'b1;
                end
                if (w_gnt_b && req_b_lock_i && LP_LOCK_EN) begin
                    w_state_nxt = LOCK_B;
                    w_lock_nxt  = 4'd1;
                end else if (w_pend_b && !w_gnt_b &&
                             ((r_starve_cnt + 4'd1) >= LP_STARVE_LIMIT)) begin
                    w_state_nxt = PRI_B;
                end
            end

            PRI_B: begin
                if (w_pend_b) begin
                    w_gnt_b = 1'b1;
                end else if (w_pend_a) begin
                    w_gnt_a = 1'b1;
                end
                if (w_gnt_b && req_b_lock_i && LP_LOCK_EN) begin
                    w_state_nxt = LOCK_B;
                    w_lock_nxt  = 4'd1;
                end else begin
                    w_state_nxt = PRI_A;
                end
            end

            LOCK_B: begin
                if (w_pend_b) begin
                    w_gnt_b = 1'b1;
                    // A grant that drops the lock or reaches the cap is the last grant of the burst.
                    if (!req_b_lock_i || (w_lock_inc >= LP_LOCK_MAX)) begin
                        w_state_nxt = PRI_A;
                        w_lock_nxt  = 4'd0;
                    end else begin
                        w_lock_nxt  = w_lock_inc;
                    end
                end else begin
                    // B went idle: hand this cycle to A and release the burst.
                    w_gnt_a     = w_pend_a;
                    w_state_nxt = PRI_A;
                    w_lock_nxt  = 4'd0;
                end
            end

            default: begin
                w_state_nxt = PRI_A;
                w_lock_nxt  = 4'd0;
            end
        endcase

        // Starvation only accumulates while B waits and is refused.
        if (w_gnt_b || !w_pend_b) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve_cnt < LP_STARVE_LIMIT) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end else begin
            w_starve_nxt = r_starve_cnt;
        end

        // No request is taken while reset is held, so none can produce an ack.
        if (rst_i) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end
    end

    // Arbitration state register and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= PRI_A;
            r_starve_cnt <= 4'd0;
            r_lock_cnt   <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_lock_cnt   <= w_lock_nxt;
        end
    end

    // Drive the RAM from the winner. With no winner, use A's address and data and write nothing.
    always_comb begin
        ram_addr_o     = w_gnt_b ? req_b_addr_i : req_a_addr_i;
        ram_data_o     = w_gnt_b ? req_b_data_i : req_a_data_i;
        ram_wr_o       = w_gnt_a ? req_a_wr_i : (w_gnt_b ? req_b_wr_i : 8'h00);
        req_a_accept_o = w_gnt_a;
        req_b_accept_o = w_gnt_b;
    end

    // --- stage p1: track which side owns the RAM response one cycle after its grant ---
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack_vld_p1 <= 1'b0;
            r_ack_sel_p1 <= 1'b0;
        end else begin
            r_ack_vld_p1 <= w_gnt_a | w_gnt_b;
            r_ack_sel_p1 <= w_gnt_b;
        end
    end

    // Read data goes to both sides unchanged, and the ack tells each side whether it is theirs.
    always_comb begin
        req_a_ack_o  = r_ack_vld_p1 & ~r_ack_sel_p1;
        req_b_ack_o  = r_ack_vld_p1 &  r_ack_sel_p1;
        req_a_data_o = ram_data_i;
        req_b_data_o = ram_data_i;
    end

endmodule

// File: tb/tb_tcm_port_arb.sv
// Testbench for tcm_port_arb: a behavioural read-first TCM sits behind the
// arbiter. Table rows and hand-built sequences give the expected winner for
// each cycle. A scoreboard queue pairs each grant with the ack and read data
// expected one cycle later.

module tb_tcm_port_arb;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_A    = 2'd1;
    localparam logic [1:0] G_B    = 2'd2;

    typedef struct {
        logic        rst;
        logic        a_rd;
        logic [7:0]  a_wr;
        logic [13:0] a_addr;
        logic [63:0] a_data;
        logic        b_rd;
        logic [7:0]  b_wr;
        logic [13:0] b_addr;
        logic [63:0] b_data;
        logic        b_lock;
        logic [1:0]  exp_g;
    } vec_t;

    typedef struct {
        logic        side;
        logic        chk;
        logic [63:0] data;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        a_rd, b_rd, b_lock;
    logic [7:0]  a_wr, b_wr;
    logic [13:0] a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic        a_accept, b_accept, a_ack, b_ack;
    logic [63:0] a_rdata, b_rdata;
    logic [13:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wr;
    logic [63:0] ram_rdata;

    logic [63:0] ram_mem   [0:16383];
    logic [63:0] exp_mem   [0:16383];
    bit          exp_known [0:16383];

    sb_t  q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    tcm_port_arb #(.STARVE_LIMIT(4), .LOCK_MAX(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_a_rd_i     (a_rd),
        .req_a_wr_i     (a_wr),
        .req_a_addr_i   (a_addr),
        .req_a_data_i   (a_data),
        .req_a_accept_o (a_accept),
        .req_a_ack_o    (a_ack),
        .req_a_data_o   (a_rdata),
        .req_b_rd_i     (b_rd),
        .req_b_wr_i     (b_wr),
        .req_b_addr_i   (b_addr),
        .req_b_data_i   (b_data),
        .req_b_lock_i   (b_lock),
        .req_b_accept_o (b_accept),
        .req_b_ack_o    (b_ack),
        .req_b_data_o   (b_rdata),
        .ram_addr_o     (ram_addr),
        .ram_data_o     (ram_wdata),
        .ram_wr_o       (ram_wr),
        .ram_data_i     (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM with a registered read and byte write enables.
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        for (int k = 0; k < 8; k++)
            if (ram_wr[k]) ram_mem[ram_addr][k*8 +: 8] <= ram_wdata[k*8 +: 8];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ard, input logic [7:0] awr,
                                input logic [13:0] aad, input logic [63:0] adt,
                                input logic brd, input logic [7:0] bwr,
                                input logic [13:0] bad_, input logic [63:0] bdt,
                                input logic lk, input logic [1:0] g);
        vec_t v;
        v.rst = r;  v.a_rd = ard; v.a_wr = awr; v.a_addr = aad; v.a_data = adt;
        v.b_rd = brd; v.b_wr = bwr; v.b_addr = bad_; v.b_data = bdt; v.b_lock = lk;
        v.exp_g = g;
        return v;
    endfunction

    // Apply one cycle of stimulus and check ack, accept and RAM drive against expectations.
    task automatic step(input vec_t v, input string tag);
        sb_t         e;
        logic [7:0]  wr;
        logic [13:0] ad;
        logic [63:0] dt;
        rst = v.rst; a_rd = v.a_rd; a_wr = v.a_wr; a_addr = v.a_addr; a_data = v.a_data;
        b_rd = v.b_rd; b_wr = v.b_wr; b_addr = v.b_addr; b_data = v.b_data; b_lock = v.b_lock;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, " ack_a"}, 64'(a_ack), 64'(!e.side));
            check({tag, " ack_b"}, 64'(b_ack), 64'(e.side));
            if (e.chk) check({tag, " rdata"}, e.side ? b_rdata : a_rdata, e.data);
        end else begin
            check({tag, " ack_a idle"}, 64'(a_ack), 64'd0);
            check({tag, " ack_b idle"}, 64'(b_ack), 64'd0);
        end
        check({tag, " accept_a"}, 64'(a_accept), 64'(v.exp_g == G_A));
        check({tag, " accept_b"}, 64'(b_accept), 64'(v.exp_g == G_B));
        wr = (v.exp_g == G_A) ? v.a_wr : (v.exp_g == G_B) ? v.b_wr : 8'h00;
        ad = (v.exp_g == G_B) ? v.b_addr : v.a_addr;
        dt = (v.exp_g == G_B) ? v.b_data : v.a_data;
        check({tag, " ram_wr"}, 64'(ram_wr), 64'(wr));
        check({tag, " ram_addr"}, 64'(ram_addr), 64'(ad));
        if (wr != 8'h00) check({tag, " ram_data"}, ram_wdata, dt);
        if (v.exp_g != G_NONE) begin
            e.side = (v.exp_g == G_B);
            e.chk  = (wr == 8'h00) && exp_known[ad];
            e.data = exp_mem[ad];
            q.push_back(e);
            for (int k = 0; k < 8; k++)
                if (wr[k]) exp_mem[ad][k*8 +: 8] = dt[k*8 +: 8];
            if (wr == 8'hFF) exp_known[ad] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a_rd = 0; a_wr = 0; a_addr = 0; a_data = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_data = 0; b_lock = 0;
        @(posedge clk);
        #1;

        // reset with both requesting, then first grant after release goes to A
        tbl.push_back(mk(1, 0, 8'hFF, 14'h005, 64'h55, 1, 8'h00, 14'h006, 64'h0, 0, G_NONE));
        tbl.push_back(mk(1, 0, 8'hFF, 14'h005, 64'h55, 1, 8'h00, 14'h006, 64'h0, 0, G_NONE));
        tbl.push_back(mk(0, 1, 8'h00, 14'h010, 64'h0,  1, 8'h00, 14'h020, 64'h0, 0, G_A));
        // A preload, partial write, read-back (expects 0x11223344DEADBEEF)
        tbl.push_back(mk(0, 0, 8'hFF, 14'h010, 64'h1122334455667788, 0, 8'h00, 14'h0, 64'h0, 0, G_A));
        tbl.push_back(mk(0, 0, 8'h0F, 14'h010, 64'h00000000DEADBEEF, 0, 8'h00, 14'h0, 64'h0, 0, G_A));
        tbl.push_back(mk(0, 1, 8'h00, 14'h010, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_A));
        tbl.push_back(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE));
        // B write to top address followed by A read of it
        tbl.push_back(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'hFF, 14'h3FFF, 64'h0123456789ABCDEF, 0, G_B));
        tbl.push_back(mk(0, 1, 8'h00, 14'h3FFF, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_A));
        tbl.push_back(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE));
        // continuous contention: A,A,A,A,B repeating
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, 1, 8'h00, 14'h3FFF, 64'h0, 1, 8'h00, 14'h010, 64'h0, 0,
                             (k % 5 == 4) ? G_B : G_A));
        tbl.push_back(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

        // full locked burst: 8 B grants, then A
        step(mk(0, 0, 8'h00, 14'h3FFF, 64'h0, 0, 8'hFF, 14'h100, 64'h100, 1, G_B), "lock0");
        for (int k = 1; k < 8; k++)
            step(mk(0, 1, 8'h00, 14'h3FFF, 64'h0, 0, 8'hFF, 14'(14'h100 + k), 64'(k), 1, G_B),
                 $sformatf("lock%0d", k));
        step(mk(0, 1, 8'h00, 14'h3FFF, 64'h0, 0, 8'hFF, 14'h108, 64'h8, 1, G_A), "lock8");
        step(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE), "lockidle");
        step(mk(0, 1, 8'h00, 14'h103, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_A), "lockrd");
        step(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE), "lockrdack");

        // lock dropped at the third grant -> A wins the fourth cycle
        step(mk(0, 0, 8'h00, 14'h3FFF, 64'h0, 1, 8'h00, 14'h103, 64'h0, 1, G_B), "drop0");
        step(mk(0, 1, 8'h00, 14'h3FFF, 64'h0, 1, 8'h00, 14'h103, 64'h0, 1, G_B), "drop1");
        step(mk(0, 1, 8'h00, 14'h3FFF, 64'h0, 1, 8'h00, 14'h103, 64'h0, 0, G_B), "drop2");
        step(mk(0, 1, 8'h00, 14'h3FFF, 64'h0, 1, 8'h00, 14'h103, 64'h0, 0, G_A), "drop3");
        step(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE), "dropidle");

        // B goes idle during lock -> A granted that cycle
        step(mk(0, 0, 8'h00, 14'h000, 64'h0, 1, 8'h00, 14'h010, 64'h0, 1, G_B), "bidle0");
        step(mk(0, 1, 8'h00, 14'h010, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_A), "bidle1");
        step(mk(0, 1, 8'h00, 14'h010, 64'h0, 1, 8'h00, 14'h010, 64'h0, 0, G_A), "bidle2");
        step(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE), "bidle3");

        // reset in the middle of contention clears starvation and drops the pending read
        for (int k = 0; k < 3; k++)
            step(mk(0, 1, 8'h00, 14'h010, 64'h0, 1, 8'h00, 14'h3FFF, 64'h0, 0, G_A),
                 $sformatf("pre%0d", k));
        step(mk(1, 1, 8'h00, 14'h010, 64'h0, 1, 8'h00, 14'h3FFF, 64'h0, 0, G_NONE), "rstrd");
        for (int k = 0; k < 5; k++)
            step(mk(0, 1, 8'h00, 14'h010, 64'h0, 1, 8'h00, 14'h3FFF, 64'h0, 0,
                    (k == 4) ? G_B : G_A), $sformatf("post%0d", k));
        step(mk(0, 0, 8'h00, 14'h000, 64'h0, 0, 8'h00, 14'h0, 64'h0, 0, G_NONE), "end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
